// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Single-entry valid/ready stage with flush. Writeback data is forwarded
// into rs1/rs2 operands both when an instruction is captured and while it
// is held by a stalled execute stage.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall/flush counters.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FUN_W      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [XLEN-1:0]       imm_ext_i,
  input  logic                  alu_sel_i,
  input  logic [FUN_W-1:0]      alu_fun_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  input  logic                  flush_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       reg_a_o,
  output logic [XLEN-1:0]       reg_b_o,
  output logic [XLEN-1:0]       imm_ext_o,
  output logic                  alu_sel_o,
  output logic [FUN_W-1:0]      alu_fun_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
`endif
  output logic                  rd_we_o
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic                  accept;
  logic                  hold;
  logic [XLEN-1:0]       cap_a;
  logic [XLEN-1:0]       cap_b;
  logic                  hold_fwd_a;
  logic                  hold_fwd_b;

  assign valid_o = valid_q;

  // Handshake: single entry, so we can take a new one only if empty or draining.
  always_comb begin
    ready_o = rst_ni && (!valid_q || ready_i);
    accept  = valid_i && ready_o && !flush_i;
    hold    = valid_q && !ready_i;
  end

  // Forwarding selects; x0 is hardwired zero and never forwarded.
  always_comb begin
    cap_a      = rs1_data_i;
    cap_b      = rs2_data_i;
    hold_fwd_a = 1'b0;
    hold_fwd_b = 1'b0;
    if (wb_we_i && (wb_rd_i == rs1_addr_i) && (rs1_addr_i != '0)) cap_a = wb_data_i;
    if (wb_we_i && (wb_rd_i == rs2_addr_i) && (rs2_addr_i != '0)) cap_b = wb_data_i;
    if (wb_we_i && (wb_rd_i == rs1_q) && (rs1_q != '0)) hold_fwd_a = 1'b1;
    if (wb_we_i && (wb_rd_i == rs2_q) && (rs2_q != '0)) hold_fwd_b = 1'b1;
  end

  // Pipeline register: flush beats accept beats hold; an unreplaced drain empties.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      reg_a_o   <= '0;
      reg_b_o   <= '0;
      imm_ext_o <= '0;
      alu_sel_o <= 1'b0;
      alu_fun_o <= '0;
      rd_addr_o <= '0;
      rd_we_o   <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      rs1_q     <= rs1_addr_i;
      rs2_q     <= rs2_addr_i;
      reg_a_o   <= cap_a;
      reg_b_o   <= cap_b;
      imm_ext_o <= imm_ext_i;
      alu_sel_o <= alu_sel_i;
      alu_fun_o <= alu_fun_i;
      rd_addr_o <= rd_addr_i;
      rd_we_o   <= rd_we_i && (rd_addr_i != '0);
    end else if (hold) begin
      if (hold_fwd_a) reg_a_o <= wb_data_i;
      if (hold_fwd_b) reg_b_o <= wb_data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Saturating event counters for stall cycles and killed instructions.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (valid_q && !ready_i && !flush_i && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && (valid_q || (valid_i && ready_o)) && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register that feeds the ALU operands, immediate, operand-select and function code.
- Uses a single-entry valid/ready handshake with stall and flush.
- Applies writeback forwarding at capture and while holding, so a stalled instruction never executes with stale rs1/rs2 data.
- Output latency is one cycle from accepted input.

Parameters:
XLEN, 32, data width of operands, immediate and writeback data
REG_ADDR_W, 5, register address width
FUN_W, 4, ALU function code width

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous active-low reset
valid_i  input  1  decoded instruction present
ready_o  output  1  stage can accept this cycle
rs1_addr_i  input  REG_ADDR_W  source 1 address
rs2_addr_i  input  REG_ADDR_W  source 2 address
rs1_data_i  input  XLEN  register-file read data 1
rs2_data_i  input  XLEN  register-file read data 2
imm_ext_i  input  XLEN  sign-extended immediate
alu_sel_i  input  1  1 selects immediate as operand B
alu_fun_i  input  FUN_W  ALU function code
rd_addr_i  input  REG_ADDR_W  destination address
rd_we_i  input  1  destination write enable
flush_i  input  1  kill held and incoming instruction
wb_we_i  input  1  writeback write enable
wb_rd_i  input  REG_ADDR_W  writeback destination
wb_data_i  input  XLEN  writeback data
valid_o  output  1  execute-stage instruction valid
ready_i  input  1  execute stage accepts
reg_a_o  output  XLEN  operand A to ALU
reg_b_o  output  XLEN  operand B (rs2) to ALU
imm_ext_o  output  XLEN  immediate to ALU
alu_sel_o  output  1  operand-select to ALU
alu_fun_o  output  FUN_W  function code to ALU
rd_addr_o  output  REG_ADDR_W  destination address
rd_we_o  output  1  destination write enable

Behaviour:
- Reset (rst_ni=0 at a clock edge): valid_o=0, all data/control outputs=0. ready_o=0 while rst_ni=0, combinationally.
- Out of reset: ready_o = !valid_o || ready_i (combinational, single entry, no skid buffer).
- Accept when valid_i && ready_o && !flush_i. Next cycle:
  - valid_o=1.
  - All fields are registered.
  - rs1/rs2 addresses are held internally.
- Drain: valid_o && ready_i with no new accept -> valid_o=0 next cycle. Accept and drain in the same cycle -> new entry replaces old (back-to-back throughput 1/cycle).
- Hold: valid_o && !ready_i -> all outputs stable except the hold-time forwarding below.
- Capture forwarding: if wb_we_i && wb_rd_i==rs1_addr_i && rs1_addr_i!=0, reg_a is captured from wb_data_i; otherwise from rs1_data_i. Same rule for reg_b with rs2.
- Hold-time forwarding: while holding, if wb_we_i && wb_rd_i==held rs1 && held rs1!=0, reg_a_o <= wb_data_i. Same rule for reg_b_o.
- Address x0 is never forwarded. rd_we_o is forced 0 when rd_addr_i==0.
- Flush: flush_i=1 -> valid_o=0 next cycle and the incoming instruction is discarded. Flush has priority over accept and hold. Data outputs may keep old values; consumers qualify with valid_o.
- Flush while ready_i=0 still clears valid_o.
- Reset mid-stall: valid_o=0 and outputs cleared; the held instruction is lost.
- Operands pass through unmodified; no arithmetic in this block.

Optional Feature:
Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o (32) and flush_cnt_o (32).
  - stall_cnt_o increments each cycle with valid_o && !ready_i && !flush_i.
  - flush_cnt_o increments each cycle with flush_i && (valid_o || (valid_i && ready_o)).
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- Undefined: ports and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, then valid_i=1, rs1_data_i=5, rs2_data_i=7, alu_fun_i=4'b0001, ready_i=1 -> next cycle valid_o=1, reg_a_o=5, reg_b_o=7, alu_fun_o=1.
- Capture forwarding: rs1_addr_i=3, rs1_data_i=1, wb_we_i=1, wb_rd_i=3, wb_data_i=32'hDEAD_BEEF -> reg_a_o=32'hDEAD_BEEF. Repeat with rs1_addr_i=0 -> reg_a_o=1.
- Stall with hold forwarding: entry held with rs2=8, ready_i=0 for 3 cycles; cycle 2 writeback x8=32'h1234 -> reg_b_o=32'h1234 from next cycle; other outputs unchanged; ready_o=0 throughout.
- Back-to-back stream of 4 instructions with ready_i=1 -> one valid_o per cycle, in order, no bubbles.
- Flush: flush_i with valid_i=1 and valid_o=1, ready_i=0 -> valid_o=0 next cycle; incoming instruction never appears.
- rd_addr_i=0, rd_we_i=1 -> rd_we_o=0. Under ID_EX_PERF_CNT_EN: after the stall scenario, stall_cnt_o=3 and flush_cnt_o increments by 1 on the flush.
